// File: rtl/adder_arbiter_pkg.sv
// Shared types and helpers for the adder arbiter: saturation limits of the
// default datapath width and the round-robin winner search.
package adder_arb_pkg;

  localparam int MAX_REQ   = 32;
  localparam int DEF_WIDTH = 16;

  localparam logic signed [DEF_WIDTH-1:0] MAX_VAL = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic signed [DEF_WIDTH-1:0] MIN_VAL = {1'b1, {(DEF_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } pick_t;

  // Scans ptr, ptr+1, ... modulo n and returns the first set valid bit.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr, input int n);
    pick_t p;
    int    j;
    p = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      j = ptr + k;
      if (j >= n) j = j - n;
      if (k < n && !p.found && valid[j[4:0]]) begin
        p.found = 1'b1;
        p.idx   = j[4:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/adder_arbiter_adder.sv
// Pipelined saturating fixed-point adder; every stage freezes while stall is high.
module adder #(
  parameter int INPUT_A_WIDTH = 16,
  parameter int INPUT_B_WIDTH = 16,
  parameter int OUTPUT_WIDTH  = 16,
  parameter int INPUT_A_FRAC  = 8,
  parameter int INPUT_B_FRAC  = 8,
  parameter int OUTPUT_FRAC   = 8,
  parameter int DELAY         = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     stall,
  input  logic [INPUT_A_WIDTH-1:0] a,
  input  logic [INPUT_B_WIDTH-1:0] b,
  output logic [OUTPUT_WIDTH-1:0]  out,
  output logic                     done
);

  // Operands are aligned to the output binary point before the sum.
  localparam int SHA = OUTPUT_FRAC - INPUT_A_FRAC;
  localparam int SHB = OUTPUT_FRAC - INPUT_B_FRAC;
  localparam int AW  = INPUT_A_WIDTH + SHA;
  localparam int BW  = INPUT_B_WIDTH + SHB;
  localparam int MW  = (AW > BW) ? ((AW > OUTPUT_WIDTH) ? AW : OUTPUT_WIDTH)
                                 : ((BW > OUTPUT_WIDTH) ? BW : OUTPUT_WIDTH);
  localparam int EW  = MW + 1;

  localparam logic signed [EW-1:0] HI = EW'((64'sd1 <<< (OUTPUT_WIDTH-1)) - 64'sd1);
  localparam logic signed [EW-1:0] LO = -HI - EW'(1);

  logic signed [EW-1:0]     a_ext, b_ext, sum;
  logic [OUTPUT_WIDTH-1:0]  sat;
  logic [OUTPUT_WIDTH-1:0]  data_q [DELAY];
  logic [DELAY-1:0]         vld_q;

  assign a_ext = EW'($signed(a)) <<< SHA;
  assign b_ext = EW'($signed(b)) <<< SHB;
  assign sum   = a_ext + b_ext;

  always_comb begin
    sat = OUTPUT_WIDTH'(sum);
    if (sum > HI)      sat = OUTPUT_WIDTH'(HI);
    else if (sum < LO) sat = OUTPUT_WIDTH'(LO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int k = 0; k < DELAY; k++) data_q[k] <= '0;
    end else if (!stall) begin
      vld_q[0]  <= en;
      data_q[0] <= sat;
      for (int k = 1; k < DELAY; k++) begin
        vld_q[k]  <= vld_q[k-1];
        data_q[k] <= data_q[k-1];
      end
    end
  end

  assign out  = data_q[DELAY-1];
  assign done = vld_q[DELAY-1];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one saturating adder among NUM_REQ requesters.
// Handshake: a transfer happens on a cycle where valid & ready are both high; a stalled response freezes everything.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC       = 8,
  parameter int DELAY      = 1,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic                          busy
);

  localparam int CW = $clog2(DELAY + 2);

  logic                  stall, issue, done, rsp_fire;
  logic [DATA_WIDTH-1:0] op_a, op_b, sum_out;
  logic [ID_WIDTH-1:0]   ptr, win_id;
  logic [ID_WIDTH-1:0]   tag_q [DELAY];
  logic [CW-1:0]         outstanding;
  pick_t                 pick;

  assign rsp_valid = done & ~reset;
  assign stall     = rsp_valid & ~rsp_ready;
  assign rsp_fire  = rsp_valid & rsp_ready;

  always_comb begin
    pick      = rr_pick(MAX_REQ'(req_valid), int'(ptr), NUM_REQ);
    win_id    = pick.idx[ID_WIDTH-1:0];
    req_ready = '0;
    if (!reset && !stall && pick.found) req_ready[win_id] = 1'b1;
  end

  assign issue = |(req_valid & req_ready);
  assign op_a  = req_a[win_id*DATA_WIDTH +: DATA_WIDTH];
  assign op_b  = req_b[win_id*DATA_WIDTH +: DATA_WIDTH];

  adder #(
    .INPUT_A_WIDTH(DATA_WIDTH),
    .INPUT_B_WIDTH(DATA_WIDTH),
    .OUTPUT_WIDTH (DATA_WIDTH),
    .INPUT_A_FRAC (FRAC),
    .INPUT_B_FRAC (FRAC),
    .OUTPUT_FRAC  (FRAC),
    .DELAY        (DELAY)
  ) u_adder (
    .clk  (clk),
    .reset(reset),
    .en   (issue),
    .stall(stall),
    .a    (op_a),
    .b    (op_b),
    .out  (sum_out),
    .done (done)
  );

  // Requester IDs travel alongside the adder stages so rsp_id lines up with rsp_data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DELAY; k++) tag_q[k] <= '0;
    end else if (!stall) begin
      tag_q[0] <= win_id;
      for (int k = 1; k < DELAY; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr         <= '0;
      outstanding <= '0;
    end else begin
      if (issue) ptr <= (win_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
      if (issue && !rsp_fire)      outstanding <= outstanding + 1'b1;
      else if (!issue && rsp_fire) outstanding <= outstanding - 1'b1;
    end
  end

  assign rsp_data = sum_out;
  assign rsp_id   = tag_q[DELAY-1];
  assign busy     = (outstanding != '0);

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomised and directed bench for adder_arbiter against a queue-based latency model.
module tb_adder_arbiter;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int DELAY = 3;
  localparam int IW    = 2;
  localparam int EW    = IW + DW;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a, req_b;
  logic            rsp_valid, rsp_ready, busy;
  logic [DW-1:0]   rsp_data;
  logic [IW-1:0]   rsp_id;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: in-flight ops in issue order, each with its age in unstalled cycles.
  logic [EW-1:0] exp_q[$];
  int            age_q[$];
  int            mptr = 0;

  int            grant_log[$];
  logic [EW-1:0] rsp_log[$];

  adder_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .FRAC(8), .DELAY(DELAY)) dut (
    .clk      (clk),
    .reset    (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_id   (rsp_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int sa, sb, s;
    sa = a[DW-1] ? int'(a) - 65536 : int'(a);
    sb = b[DW-1] ? int'(b) - 65536 : int'(b);
    s  = sa + sb;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return DW'(s);
  endfunction

  // Compare process: outputs are stable at the falling edge; the model then steps over the next rising edge.
  always @(negedge clk) begin
    logic       ev, stl, found;
    int         idx, j;
    logic [N-1:0] exp_ready;
    if (rst) begin
      check("reset_req_ready", req_ready, 0);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_rsp_data", rsp_data, 0);
      exp_q.delete();
      age_q.delete();
      mptr = 0;
    end else begin
      ev = (exp_q.size() > 0) && (age_q[0] == DELAY);
      check("rsp_valid", rsp_valid, ev);
      if (ev) begin
        check("rsp_data", rsp_data, exp_q[0][DW-1:0]);
        check("rsp_id", rsp_id, exp_q[0][EW-1:DW]);
      end
      stl   = ev && !rsp_ready;
      found = 1'b0;
      idx   = 0;
      if (!stl) begin
        for (int k = 0; k < N; k++) begin
          j = (mptr + k) % N;
          if (!found && req_valid[j]) begin
            found = 1'b1;
            idx   = j;
          end
        end
      end
      exp_ready = found ? N'(1 << idx) : '0;
      check("req_ready", req_ready, exp_ready);
      check("busy", busy, exp_q.size() != 0);
      check("outstanding", dut.outstanding, exp_q.size());
      for (int k = 0; k < N; k++) if (req_ready[k]) grant_log.push_back(k);
      if (rsp_valid && rsp_ready) rsp_log.push_back({rsp_id, rsp_data});
      if (!stl) begin
        if (ev) begin
          void'(exp_q.pop_front());
          void'(age_q.pop_front());
        end
        foreach (age_q[k]) age_q[k]++;
        if (found) begin
          exp_q.push_back({IW'(idx), sat_add(req_a[idx*DW +: DW], req_b[idx*DW +: DW])});
          age_q.push_back(1);
          mptr = (idx + 1) % N;
        end
      end
    end
  end

  task automatic step(input logic [N-1:0] v, input logic r);
    req_valid = v;
    rsp_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [DW-1:0] a, input logic [DW-1:0] b);
    for (int i = 0; i < N; i++) begin
      req_a[i*DW +: DW] = a;
      req_b[i*DW +: DW] = b;
    end
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*DW +: DW] = DW'($urandom);
      req_b[i*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic drain(input logic rand_ready);
    int cyc = 0;
    while ((busy || rsp_valid) && cyc < 200) begin
      step('0, rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      cyc++;
    end
    check("drain_timeout", cyc < 200, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step('0, 1'b1);
    step('0, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    req_a = '0;
    req_b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Round robin over four always-valid requesters.
    grant_log.delete(); rsp_log.delete();
    set_all(16'h0100, 16'h0080);
    repeat (5) step('1, 1'b1);
    drain(1'b0);
    check("rr_grant_count", grant_log.size(), 5);
    check("rr_rsp_count", rsp_log.size(), 5);
    for (int k = 0; k < 5 && k < grant_log.size() && k < rsp_log.size(); k++) begin
      check("rr_grant", grant_log[k], k % 4);
      check("rr_rsp_id", rsp_log[k][EW-1:DW], k % 4);
      check("rr_rsp_data", rsp_log[k][DW-1:0], 16'h0180);
    end

    // Saturation at both ends, requester 0 only.
    grant_log.delete(); rsp_log.delete();
    set_all(16'h7F00, 16'h0200);
    step(4'b0001, 1'b1);
    set_all(16'h8100, 16'hFE00);
    step(4'b0001, 1'b1);
    drain(1'b0);
    check("sat_count", rsp_log.size(), 2);
    if (rsp_log.size() == 2) begin
      check("sat_pos", rsp_log[0][DW-1:0], 16'h7FFF);
      check("sat_neg", rsp_log[1][DW-1:0], 16'h8000);
    end

    // Backpressure for five cycles with a full pipeline.
    do_reset();
    grant_log.delete(); rsp_log.delete();
    set_all(16'h0040, 16'h0020);
    repeat (4) step('1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      req_valid = '1;
      rsp_ready = 1'b0;
      #1;
      check("stall_no_grant", req_ready, 0);
      check("stall_rsp_valid", rsp_valid, 1);
      @(posedge clk);
      #1;
    end
    repeat (4) step('1, 1'b1);
    drain(1'b0);
    check("bp_rsp_count", rsp_log.size(), 8);
    for (int k = 0; k < rsp_log.size(); k++) begin
      check("bp_rsp_id", rsp_log[k][EW-1:DW], k % 4);
      check("bp_rsp_data", rsp_log[k][DW-1:0], 16'h0060);
    end

    // Only requesters 1 and 3 active.
    do_reset();
    grant_log.delete(); rsp_log.delete();
    repeat (4) step(4'b1010, 1'b1);
    drain(1'b0);
    check("skip_count", grant_log.size(), 4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++) check("skip_grant", grant_log[k], (k % 2) ? 3 : 1);

    // Reset with two ops in flight.
    do_reset();
    repeat (2) step('1, 1'b1);
    step('0, 1'b1);
    grant_log.delete(); rsp_log.delete();
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) step('0, 1'b1);
    check("midrst_no_rsp", rsp_log.size(), 0);
    step('1, 1'b1);
    check("midrst_grants", grant_log.size(), 1);
    if (grant_log.size() > 0) check("midrst_first_grant", grant_log[0], 0);
    drain(1'b0);

    // Ten ops under random stalls; responses must match issues.
    grant_log.delete(); rsp_log.delete();
    cyc = 0;
    while (grant_log.size() < 10 && cyc < 300) begin
      randomize_ops();
      step(N'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      cyc++;
    end
    check("ops_timeout", cyc < 300, 1);
    drain(1'b1);
    check("ops_rsp_eq_issue", rsp_log.size(), grant_log.size());

    // Long random run.
    for (int k = 0; k < 600; k++) begin
      randomize_ops();
      step(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end
    drain(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
